// File: rtl/mult_pkg.sv
// Shared types and encodings for the multicycle datapath: ALU operations,
// R-type funct codes, mux select encodings and the controller state width.
package mult_pkg;

  localparam int STATE_W = 4;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_e;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_RSVD  = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_HOLD   = 2'b11;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // Unknown funct codes and the reserved aluop both fall back to add.
  function automatic alu_op_e decode_alu(input logic [1:0] aluop, input logic [5:0] funct);
    alu_op_e op;
    case (aluop)
      ALUOP_SUB: op = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_ADD: op = ALU_ADD;
          FUNCT_SUB: op = ALU_SUB;
          FUNCT_AND: op = ALU_AND;
          FUNCT_OR:  op = ALU_OR;
          FUNCT_SLT: op = ALU_SLT;
          default:   op = ALU_ADD;
        endcase
      end
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mult_alu.sv
// 32-bit ALU: add/sub/and/or/signed set-less-than, wrapping arithmetic,
// combinational zero flag.
module mult_alu
  import mult_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_e     op,
  output logic [31:0] result,
  output logic        zero
);

  // Operation select.
  always_comb begin
    result = 32'd0;
    case (op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLT: result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: result = a + b;
    endcase
  end

  assign zero = (result == 32'd0);

endmodule

// File: rtl/mult_datapath.sv
// Multicycle MIPS-style datapath: PC, IR, MDR, A/B, ALUOut, 32x32 register
// file and the controller's state register, steered by external controls.
module mult_datapath
  import mult_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pcwrite,
  input  logic               pcwritecond,
  input  logic               iord,
  input  logic               memread,
  input  logic               memwrite,
  input  logic               irwrite,
  input  logic               memtoreg,
  input  logic [1:0]         pcsource,
  input  logic [1:0]         aluop,
  input  logic [1:0]         alusrcb,
  input  logic               alusrca,
  input  logic               regwrite,
  input  logic               regdst,
  input  logic [STATE_W-1:0] ns,
  output logic [STATE_W-1:0] s,
  output logic [5:0]         op,
  output logic [31:0]        mem_addr,
  output logic [31:0]        mem_wdata,
  output logic               mem_rd,
  output logic               mem_wr,
  input  logic [31:0]        mem_rdata
);

  logic [31:0] pc_r, ir_r, mdr_r, a_r, b_r, aluout_r;
  logic [31:0] rf_r [32];

  logic [31:0] rd_a_s, rd_b_s, src_a_s, src_b_s, imm_ext_s;
  logic [31:0] alu_result_s, pc_next_s, wr_data_s;
  logic [4:0]  wr_dst_s;
  logic        zero_s, pc_load_s;
  alu_op_e     alu_op_s;

  assign op        = ir_r[31:26];
  assign mem_addr  = iord ? aluout_r : pc_r;
  assign mem_wdata = b_r;
  assign mem_rd    = memread & rst_n;
  assign mem_wr    = memwrite & rst_n;

  // Register 0 is hardwired to zero on the read side as well.
  assign rd_a_s = (ir_r[25:21] == 5'd0) ? 32'd0 : rf_r[ir_r[25:21]];
  assign rd_b_s = (ir_r[20:16] == 5'd0) ? 32'd0 : rf_r[ir_r[20:16]];

  assign imm_ext_s = {{16{ir_r[15]}}, ir_r[15:0]};
  assign src_a_s   = alusrca ? a_r : pc_r;
  assign alu_op_s  = decode_alu(aluop, ir_r[5:0]);
  assign pc_load_s = pcwrite | (pcwritecond & zero_s);
  assign wr_dst_s  = regdst ? ir_r[15:11] : ir_r[20:16];
  assign wr_data_s = memtoreg ? mdr_r : aluout_r;

  // ALU operand B and next-PC selection.
  always_comb begin
    src_b_s   = b_r;
    pc_next_s = pc_r;
    case (alusrcb)
      SRCB_B:       src_b_s = b_r;
      SRCB_FOUR:    src_b_s = 32'd4;
      SRCB_IMM:     src_b_s = imm_ext_s;
      SRCB_IMM_SH2: src_b_s = {imm_ext_s[29:0], 2'b00};
      default:      src_b_s = b_r;
    endcase
    case (pcsource)
      PCSRC_ALU:    pc_next_s = alu_result_s;
      PCSRC_ALUOUT: pc_next_s = aluout_r;
      PCSRC_JUMP:   pc_next_s = {pc_r[31:28], ir_r[25:0], 2'b00};
      PCSRC_HOLD:   pc_next_s = pc_r;
      default:      pc_next_s = pc_r;
    endcase
  end

  mult_alu u_alu (
    .a      (src_a_s),
    .b      (src_b_s),
    .op     (alu_op_s),
    .result (alu_result_s),
    .zero   (zero_s)
  );

  // Architectural and pipeline-stage registers plus controller state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_r     <= RESET_PC;
      s        <= '0;
      ir_r     <= 32'd0;
      mdr_r    <= 32'd0;
      a_r      <= 32'd0;
      b_r      <= 32'd0;
      aluout_r <= 32'd0;
    end else begin
      s        <= ns;
      mdr_r    <= mem_rdata;
      a_r      <= rd_a_s;
      b_r      <= rd_b_s;
      aluout_r <= alu_result_s;
      if (irwrite) ir_r <= mem_rdata;
      if (pc_load_s) pc_r <= pc_next_s;
    end
  end

  // Register file write port; reads above see the pre-write contents.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf_r[i] <= 32'd0;
    end else if (regwrite && (wr_dst_s != 5'd0)) begin
      rf_r[wr_dst_s] <= wr_data_s;
    end
  end

endmodule

// File: tb/tb_mult_datapath.sv
// Scenario bench for mult_datapath: expectations are queued as stimulus is
// driven and popped when the corresponding output is sampled.
module tb_mult_datapath;
  import mult_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg;
  logic [1:0]  pcsource, aluop, alusrcb;
  logic        alusrca, regwrite, regdst;
  logic [3:0]  ns, s;
  logic [5:0]  op;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rd, mem_wr;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mult_datapath #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .pcwrite(pcwrite), .pcwritecond(pcwritecond),
    .iord(iord), .memread(memread), .memwrite(memwrite), .irwrite(irwrite),
    .memtoreg(memtoreg), .pcsource(pcsource), .aluop(aluop), .alusrcb(alusrcb),
    .alusrca(alusrca), .regwrite(regwrite), .regdst(regdst), .ns(ns), .s(s),
    .op(op), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .mem_rdata(mem_rdata)
  );

  task automatic idle();
    pcwrite = 1'b0; pcwritecond = 1'b0; iord = 1'b0; memread = 1'b0;
    memwrite = 1'b0; irwrite = 1'b0; memtoreg = 1'b0; pcsource = 2'b00;
    aluop = 2'b00; alusrcb = 2'b00; alusrca = 1'b0; regwrite = 1'b0;
    regdst = 1'b0; ns = 4'd0; mem_rdata = 32'd0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Load $idx from MDR through an lw-shaped IR (rt = idx).
  task automatic write_reg(input logic [4:0] idx, input logic [31:0] val);
    idle(); irwrite = 1'b1; mem_rdata = {6'h23, 5'd0, idx, 16'h0000}; step();
    idle(); mem_rdata = val; step();
    idle(); regwrite = 1'b1; memtoreg = 1'b1; step();
    idle();
  endtask

  // Observe $idx through B on mem_wdata.
  task automatic read_reg(input logic [4:0] idx, output logic [31:0] val);
    idle(); irwrite = 1'b1; mem_rdata = {6'h23, 5'd0, idx, 16'h0000}; step();
    idle(); step();
    val = mem_wdata;
  endtask

  task automatic test_reset();
    exp_t e;
    idle();
    rst_n = 1'b0; memwrite = 1'b1; memread = 1'b1; pcwrite = 1'b1;
    regwrite = 1'b1; irwrite = 1'b1; ns = 4'hA; mem_rdata = 32'hFFFF_FFFF;
    sb.push_back('{name: "rst_mem_wr_low", exp: 32'd0});
    #1;
    e = sb.pop_front(); n_checks++;
    if (32'(mem_wr) !== e.exp) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, mem_wr, e.exp); end
    step(); step();
    sb.push_back('{name: "rst_mem_rd",   exp: 32'd0});
    sb.push_back('{name: "rst_pc",       exp: 32'd0});
    sb.push_back('{name: "rst_state",    exp: 32'd0});
    sb.push_back('{name: "rst_op",       exp: 32'd0});
    sb.push_back('{name: "rst_b",        exp: 32'd0});
    e = sb.pop_front(); n_checks++;
    if (32'(mem_rd) !== e.exp) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, mem_rd, e.exp); end
    e = sb.pop_front(); n_checks++;
    if (mem_addr !== e.exp) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, mem_addr, e.exp); end
    e = sb.pop_front(); n_checks++;
    if (32'(s) !== e.exp) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, s, e.exp); end
    e = sb.pop_front(); n_checks++;
    if (32'(op) !== e.exp) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, op, e.exp); end
    e = sb.pop_front(); n_checks++;
    if (mem_wdata !== e.exp) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, mem_wdata, e.exp); end
    idle(); rst_n = 1'b1;
  endtask

  task automatic test_state();
    exp_t e;
    logic [3:0] vals [3];
    vals = '{4'd3, 4'd9, 4'd15};
    for (int i = 0; i < 3; i++) begin
      idle(); ns = vals[i];
      sb.push_back('{name: "state_follow", exp: 32'(vals[i])});
      step();
      e = sb.pop_front(); n_checks++;
      if (32'(s) !== e.exp) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, s, e.exp); end
    end
  endtask

  task automatic test_fetch();
    exp_t e;
    idle();
    mem_rdata = 32'h8C22_0004; irwrite = 1'b1; memread = 1'b1;
    alusrcb = 2'b01; pcwrite = 1'b1; pcsource = 2'b00;
    sb.push_back('{name: "fetch_mem_rd",   exp: 32'd1});
    sb.push_back('{name: "fetch_addr_pc0", exp: 32'd0});
    #1;
    e = sb.pop_front(); n_checks++;
    if (32'(mem_rd) !== e.exp) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, mem_rd, e.exp); end
    e = sb.pop_front(); n_checks++;
    if (mem_addr !== e.exp) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, mem_addr, e.exp); end
    sb.push_back('{name: "fetch_op", exp: 32'h23});
    sb.push_back('{name: "fetch_pc", exp: 32'd4});
    step();
    e = sb.pop_front(); n_checks++;
    if (32'(op) !== e.exp) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, op, e.exp); end
    e = sb.pop_front(); n_checks++;
    if (mem_addr !== e.exp) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, mem_addr, e.exp); end
    idle();
  endtask

  task automatic test_rtype();
    exp_t e;
    logic [31:0] v;
    logic [1:0]  t_aluop [9];
    logic [5:0]  t_funct [9];
    logic [31:0] t_exp   [9];
    write_reg(5'd1, 32'd5);
    write_reg(5'd2, 32'd7);
    idle(); irwrite = 1'b1; mem_rdata = 32'h0022_1820; step();
    idle(); step();
    idle(); alusrca = 1'b1; aluop = 2'b10;
    sb.push_back('{name: "add_aluout", exp: 32'd12});
    sb.push_back('{name: "add_b",      exp: 32'd7});
    step();
    idle(); iord = 1'b1; #1;
    e = sb.pop_front(); n_checks++;
    if (mem_addr !== e.exp) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, mem_addr, e.exp); end
    e = sb.pop_front(); n_checks++;
    if (mem_wdata !== e.exp) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, mem_wdata, e.exp); end
    regdst = 1'b1; regwrite = 1'b1; step();
    sb.push_back('{name: "rf3_sum", exp: 32'd12});
    read_reg(5'd3, v);
    e = sb.pop_front(); n_checks++;
    if (v !== e.exp) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, v, e.exp); end

    // A = -1, B = 1 across every decode path.
    write_reg(5'd1, 32'hFFFF_FFFF);
    write_reg(5'd2, 32'd1);
    t_aluop = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01, 2'b11};
    t_funct = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h3F, 6'h22, 6'h20, 6'h22};
    t_exp   = '{32'h0000_0000, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFF,
                32'h0000_0001, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFE,
                32'h0000_0000};
    for (int i = 0; i < 9; i++) begin
      idle(); irwrite = 1'b1; mem_rdata = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, t_funct[i]}; step();
      idle(); step();
      idle(); alusrca = 1'b1; aluop = t_aluop[i];
      sb.push_back('{name: $sformatf("alu_op%0d_f%02h", t_aluop[i], t_funct[i]), exp: t_exp[i]});
      step();
      idle(); iord = 1'b1; #1;
      e = sb.pop_front(); n_checks++;
      if (mem_addr !== e.exp) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, mem_addr, e.exp); end
    end
    idle();
  endtask

  task automatic test_branch();
    exp_t e;
    logic [31:0] exp_pc [3];
    exp_pc = '{32'h0000_0040, 32'h0000_0040, 32'h0000_007C};
    write_reg(5'd4, 32'd9);
    write_reg(5'd5, 32'd9);
    for (int i = 0; i < 3; i++) begin
      if (i == 1) write_reg(5'd5, 32'd3);
      idle(); irwrite = 1'b1; mem_rdata = 32'h1085_000F; step();
      idle(); alusrcb = 2'b11; step();
      idle(); alusrca = 1'b1; aluop = 2'b01; pcwritecond = 1'b1;
      pcsource = 2'b01; pcwrite = (i == 2);
      sb.push_back('{name: $sformatf("branch_pc_%0d", i), exp: exp_pc[i]});
      step();
      idle(); #1;
      e = sb.pop_front(); n_checks++;
      if (mem_addr !== e.exp) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, mem_addr, e.exp); end
    end
  endtask

  task automatic test_jump();
    exp_t e;
    write_reg(5'd6, 32'h1000_0004);
    idle(); irwrite = 1'b1; mem_rdata = 32'h00C0_0000; step();
    idle(); step();
    idle(); alusrca = 1'b1; alusrcb = 2'b10; pcwrite = 1'b1; pcsource = 2'b00;
    sb.push_back('{name: "jump_setup_pc", exp: 32'h1000_0004});
    step();
    idle(); #1;
    e = sb.pop_front(); n_checks++;
    if (mem_addr !== e.exp) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, mem_addr, e.exp); end
    irwrite = 1'b1; mem_rdata = 32'h0800_0010; step();
    idle(); pcwrite = 1'b1; pcsource = 2'b10;
    sb.push_back('{name: "jump_pc", exp: 32'h1000_0040});
    step();
    idle(); #1;
    e = sb.pop_front(); n_checks++;
    if (mem_addr !== e.exp) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, mem_addr, e.exp); end
    pcwrite = 1'b1; pcsource = 2'b11; alusrcb = 2'b01;
    sb.push_back('{name: "pcsrc_hold", exp: 32'h1000_0040});
    step();
    idle(); #1;
    e = sb.pop_front(); n_checks++;
    if (mem_addr !== e.exp) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, mem_addr, e.exp); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [31:0] v;
    write_reg(5'd0, 32'hFFFF_FFFF);
    sb.push_back('{name: "rf0_zero", exp: 32'd0});
    read_reg(5'd0, v);
    e = sb.pop_front(); n_checks++;
    if (v !== e.exp) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, v, e.exp); end
    write_reg(5'd5, 32'h1111_1111);
    idle(); mem_rdata = 32'h2222_2222; step();
    idle(); regwrite = 1'b1; memtoreg = 1'b1;
    sb.push_back('{name: "rf5_pre_write",  exp: 32'h1111_1111});
    sb.push_back('{name: "rf5_post_write", exp: 32'h2222_2222});
    step();
    e = sb.pop_front(); n_checks++;
    if (mem_wdata !== e.exp) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, mem_wdata, e.exp); end
    idle(); step();
    e = sb.pop_front(); n_checks++;
    if (mem_wdata !== e.exp) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, mem_wdata, e.exp); end
  endtask

  task automatic test_ir_and_reg_write();
    exp_t e;
    logic [31:0] v;
    idle(); irwrite = 1'b1; mem_rdata = 32'h8C08_0000; step();
    idle(); mem_rdata = 32'h0000_ABCD; step();
    idle(); irwrite = 1'b1; regwrite = 1'b1; memtoreg = 1'b1; mem_rdata = 32'h8C09_0000;
    sb.push_back('{name: "old_ir_dest_rf8", exp: 32'h0000_ABCD});
    sb.push_back('{name: "new_ir_dest_rf9", exp: 32'd0});
    step();
    read_reg(5'd8, v);
    e = sb.pop_front(); n_checks++;
    if (v !== e.exp) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, v, e.exp); end
    read_reg(5'd9, v);
    e = sb.pop_front(); n_checks++;
    if (v !== e.exp) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, v, e.exp); end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    logic [31:0] v;
    write_reg(5'd10, 32'h5A5A_5A5A);
    idle(); mem_rdata = 32'hDEAD_BEEF; step();
    idle(); rst_n = 1'b0; regwrite = 1'b1; memtoreg = 1'b1; pcwrite = 1'b1;
    irwrite = 1'b1; memwrite = 1'b1; memread = 1'b1; ns = 4'h7; mem_rdata = 32'hFFFF_FFFF;
    sb.push_back('{name: "mid_rst_mem_rd", exp: 32'd0});
    #1;
    e = sb.pop_front(); n_checks++;
    if (32'(mem_rd) !== e.exp) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, mem_rd, e.exp); end
    sb.push_back('{name: "mid_rst_pc",    exp: 32'd0});
    sb.push_back('{name: "mid_rst_state", exp: 32'd0});
    sb.push_back('{name: "mid_rst_op",    exp: 32'd0});
    sb.push_back('{name: "mid_rst_rf10",  exp: 32'd0});
    step();
    e = sb.pop_front(); n_checks++;
    if (mem_addr !== e.exp) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, mem_addr, e.exp); end
    e = sb.pop_front(); n_checks++;
    if (32'(s) !== e.exp) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, s, e.exp); end
    e = sb.pop_front(); n_checks++;
    if (32'(op) !== e.exp) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, op, e.exp); end
    idle(); rst_n = 1'b1;
    read_reg(5'd10, v);
    e = sb.pop_front(); n_checks++;
    if (v !== e.exp) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, v, e.exp); end
  endtask

  initial begin
    test_reset();
    test_state();
    test_fetch();
    test_rtype();
    test_branch();
    test_jump();
    test_back_to_back();
    test_ir_and_reg_write();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_datapath.md
MULT_DATAPATH -- requirements
Module: mult_datapath

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have control inputs, 1 bit each unless stated: pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg, pcsource[1:0], aluop[1:0], alusrcb[1:0], alusrca, regwrite, regdst.
REQ-005 SHALL have ns  input  4  next control state from the controller.
REQ-006 SHALL have s  output  4  registered control state, returned to the controller.
REQ-007 SHALL have op  output  6  equal to IR[31:26].
REQ-008 SHALL have mem_addr  output  32 and mem_wdata  output  32, for memory address and write data.
REQ-009 SHALL have mem_rd  output  1 and mem_wr  output  1, as memory strobes.
REQ-010 SHALL have mem_rdata  input  32  memory read data, valid combinationally in the same cycle.

Function
REQ-011 SHALL register s <= ns on every clock edge; this register is the controller's state register.
REQ-012 SHALL load IR <= mem_rdata when irwrite=1; otherwise IR holds.
REQ-013 SHALL load MDR <= mem_rdata every cycle, and A <= rf[IR[25:21]], B <= rf[IR[20:16]], ALUOut <= alu_result every cycle.
REQ-014 SHALL drive mem_addr = iord ? ALUOut : PC, mem_wdata = B, mem_rd = memread & rst_n, mem_wr = memwrite & rst_n.
REQ-015 SHALL select srcA = alusrca ? A : PC.
REQ-016 SHALL select srcB by alusrcb: 00 = B, 01 = 32'd4, 10 = sign-extended IR[15:0], 11 = sign-extended IR[15:0] << 2.
REQ-017 SHALL decode the ALU function from aluop:
- 00 = add; 01 = sub; 11 = add (reserved).
- 10 = decode IR[5:0]: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A signed slt (result 1/0); any other funct = add.
REQ-018 SHALL compute all arithmetic modulo 2^32, with no overflow trap or flag.
REQ-019 SHALL assert zero = (alu_result == 0), combinationally.
REQ-020 SHALL load PC on the clock edge when pcwrite | (pcwritecond & zero); otherwise PC holds.
REQ-021 SHALL select next PC by pcsource:
- 00 = alu_result; 01 = ALUOut; 10 = {PC[31:28], IR[25:0], 2'b00}; 11 = PC (no change).
REQ-022 SHALL provide a register file of 32 x 32 bits with two combinational read ports and one write port.
REQ-023 SHALL write the register file on the clock edge when regwrite=1:
- destination = regdst ? IR[15:11] : IR[20:16]; data = memtoreg ? MDR : ALUOut.
REQ-024 SHALL read register 0 as 0 and ignore writes to register 0.
REQ-025 SHALL return the pre-write value when a read and a write hit the same register in the same cycle; the new value is visible the next cycle.
REQ-026 SHALL honour pcwrite and pcwritecond together: PC loads if either condition is true.
REQ-027 SHALL honour simultaneous irwrite and regwrite: the register write uses the old IR fields.

Reset
REQ-028 SHALL, on a rising edge with rst_n=0, set PC = RESET_PC, s = 0, and IR, MDR, A, B, ALUOut = 0.
REQ-029 SHALL clear all 32 register-file entries to 0 on reset.
REQ-030 SHALL make reset win over every control input, including mid-instruction; no register or register-file write occurs on that edge.
REQ-031 SHALL hold mem_rd = 0 and mem_wr = 0 while rst_n=0.

Structure
REQ-032 SHALL place in shared package mult_pkg: ALU-operation enum, funct constants (ADD/SUB/AND/OR/SLT), pcsource and alusrcb encodings, and state width 4.
REQ-033 SHALL implement the ALU as sub-module mult_alu, with inputs a, b and alu op, and outputs result and zero.
REQ-034 SHALL implement the register file inline, with no further sub-modules.

Verification
REQ-035 Reset scenario: rst_n=0 for 2 cycles with memwrite=1 -> PC=0, s=0, mem_wr=0, mem_addr=0.
REQ-036 Fetch scenario: mem_rdata=32'h8C22_0004, irwrite=1, memread=1, alusrcb=01, pcwrite=1, pcsource=00 -> IR=32'h8C22_0004, op=6'h23, PC=4.
REQ-037 R-type scenario: $1=5, $2=7, IR=32'h0022_1820, aluop=10, then regdst=1, regwrite=1 -> $3=12; with funct 0x2A, $1=-1, $2=1 -> result 1.
REQ-038 Branch scenario: beq with A=B, pcwritecond=1, aluop=01, pcsource=01, ALUOut=32'h40 -> PC=32'h40; with A!=B -> PC unchanged.
REQ-039 Jump scenario: PC=32'h1000_0004, IR=32'h0800_0010, pcsource=10, pcwrite=1 -> PC=32'h1000_0040.
REQ-040 Register-0 scenario: regwrite to $0 with data 32'hFFFF_FFFF -> $0 still reads 0; back-to-back write/read of $5 -> old value in the same cycle, new value the next cycle.
